// File: rtl/ldst_mmio_bridge_if.sv
// CPU load/store bus between the core and ldst_mmio_bridge.
interface ldst_mmio_bridge_if;
  logic [31:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [31:0] i_ldst_wrdata;
  logic [3:0]  i_ldst_byte_en;
  logic [31:0] o_ldst_rddata;

  modport master (
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
    input  o_ldst_rddata
  );

  modport slave (
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata, i_ldst_byte_en,
    output o_ldst_rddata
  );
endinterface

// File: rtl/ldst_mmio_bridge.sv
// Load/store bridge: 32 KiB RAM passthrough, LED register, one-entry TX buffer.
// Optional timer (TCOUNT/TCMP/TSTAT) compiled in with macro LDST_MMIO_TIMER_EN.
module ldst_mmio_bridge (
  input  logic                clk,
  input  logic                reset,
  ldst_mmio_bridge_if.slave   ldst,
  output logic [31:0]         o_ram_addr,
  output logic                o_ram_rd,
  output logic                o_ram_wr,
  output logic [31:0]         o_ram_wrdata,
  output logic [3:0]          o_ram_byte_en,
  input  logic [31:0]         i_ram_rddata,
  output logic [31:0]         o_led,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam logic [31:0] ADDR_LED    = 32'h0000_A000;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_A004;
  localparam logic [31:0] ADDR_TXSTAT = 32'h0000_A008;
`ifdef LDST_MMIO_TIMER_EN
  localparam logic [31:0] ADDR_TCOUNT = 32'h0000_A00C;
  localparam logic [31:0] ADDR_TCMP   = 32'h0000_A010;
  localparam logic [31:0] ADDR_TSTAT  = 32'h0000_A014;
`endif

  typedef enum logic [1:0] {TAG_NONE, TAG_RAM, TAG_PERIPH} tag_e;

  logic [DW-1:0] led_q, led_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          ovr_q, ovr_d;
  tag_e          tag_q, tag_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef LDST_MMIO_TIMER_EN
  logic [DW-1:0] tcount_q, tcount_d;
  logic [DW-1:0] tcmp_q, tcmp_d;
  logic          tstat_q, tstat_d;
`endif

  logic          ram_hit, rd_en, wr_b0, tx_hs, tx_we;
  logic [DW-1:0] prd;

  // Address decode and RAM-side passthrough; a concurrent write cancels the read
  always_comb begin
    ram_hit       = (ldst.i_ldst_addr[31:15] == 17'd0);
    rd_en         = ldst.i_ldst_rd & ~ldst.i_ldst_wr;
    wr_b0         = ldst.i_ldst_wr & ldst.i_ldst_byte_en[0];
    o_ram_addr    = ldst.i_ldst_addr;
    o_ram_wrdata  = ldst.i_ldst_wrdata;
    o_ram_byte_en = ldst.i_ldst_byte_en;
    o_ram_rd      = rd_en & ram_hit;
    o_ram_wr      = ldst.i_ldst_wr & ram_hit;
  end

  // Next-state for peripheral registers, timer and read path
  always_comb begin
    led_d      = led_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ovr_d      = ovr_q;
    prd        = '0;

    for (int b = 0; b < int'(BW); b++) begin
      if (ldst.i_ldst_wr && ldst.i_ldst_addr == ADDR_LED && ldst.i_ldst_byte_en[b]) begin
        led_d[8*b +: 8] = ldst.i_ldst_wrdata[8*b +: 8];
      end
    end

    // One-entry TX buffer: a handshake frees the slot in the same cycle a new byte may enter
    tx_hs = tx_valid_q & i_tx_ready;
    tx_we = wr_b0 & (ldst.i_ldst_addr == ADDR_TXDATA);
    if (tx_hs) begin
      tx_valid_d = 1'b0;
    end
    if (tx_we) begin
      if (!tx_valid_q || tx_hs) begin
        tx_data_d  = ldst.i_ldst_wrdata[7:0];
        tx_valid_d = 1'b1;
      end
    end
    if (wr_b0 && ldst.i_ldst_addr == ADDR_TXSTAT && ldst.i_ldst_wrdata[1]) begin
      ovr_d = 1'b0;
    end
    if (tx_we && tx_valid_q && !tx_hs) begin
      ovr_d = 1'b1;
    end

`ifdef LDST_MMIO_TIMER_EN
    tcmp_d  = tcmp_q;
    tstat_d = tstat_q;
    if (ldst.i_ldst_wr && ldst.i_ldst_addr == ADDR_TCOUNT) begin
      tcount_d = '0;
    end else begin
      tcount_d = tcount_q + DW'(1);
    end
    for (int b = 0; b < int'(BW); b++) begin
      if (ldst.i_ldst_wr && ldst.i_ldst_addr == ADDR_TCMP && ldst.i_ldst_byte_en[b]) begin
        tcmp_d[8*b +: 8] = ldst.i_ldst_wrdata[8*b +: 8];
      end
    end
    if (wr_b0 && ldst.i_ldst_addr == ADDR_TSTAT && ldst.i_ldst_wrdata[0]) begin
      tstat_d = 1'b0;
    end
    // Flag rises together with the count register reaching the compare value
    if (tcount_d == tcmp_q) begin
      tstat_d = 1'b1;
    end
`endif

    case (ldst.i_ldst_addr)
      ADDR_LED:    prd = led_q;
      ADDR_TXSTAT: prd = {30'd0, ovr_q, tx_valid_q};
`ifdef LDST_MMIO_TIMER_EN
      ADDR_TCOUNT: prd = tcount_q;
      ADDR_TCMP:   prd = tcmp_q;
      ADDR_TSTAT:  prd = {31'd0, tstat_q};
`endif
      default:     prd = '0;
    endcase

    tag_d   = rd_en ? (ram_hit ? TAG_RAM : TAG_PERIPH) : TAG_NONE;
    rdata_d = (rd_en && !ram_hit) ? prd : '0;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      tag_q      <= TAG_NONE;
      rdata_q    <= '0;
`ifdef LDST_MMIO_TIMER_EN
      tcount_q   <= '0;
      tcmp_q     <= '0;
      tstat_q    <= 1'b0;
`endif
    end else begin
      led_q      <= led_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovr_q      <= ovr_d;
      tag_q      <= tag_d;
      rdata_q    <= rdata_d;
`ifdef LDST_MMIO_TIMER_EN
      tcount_q   <= tcount_d;
      tcmp_q     <= tcmp_d;
      tstat_q    <= tstat_d;
`endif
    end
  end

  // Read-data return selected by the registered region tag
  always_comb begin
    case (tag_q)
      TAG_RAM:    ldst.o_ldst_rddata = i_ram_rddata;
      TAG_PERIPH: ldst.o_ldst_rddata = rdata_q;
      default:    ldst.o_ldst_rddata = '0;
    endcase
    o_led      = led_q;
    o_tx_data  = tx_data_q;
    o_tx_valid = tx_valid_q;
  end

endmodule

// File: tb/tb_ldst_mmio_bridge.sv
// Directed self-checking bench for ldst_mmio_bridge.
module tb_ldst_mmio_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] o_ram_addr, o_ram_wrdata, i_ram_rddata, o_led;
  logic        o_ram_rd, o_ram_wr, o_tx_valid, i_tx_ready;
  logic [3:0]  o_ram_byte_en;
  logic [7:0]  o_tx_data;
  logic [31:0] ram_mem [0:255];
  logic [31:0] rd;
  int          n_checks = 0;
  int          n_errors = 0;

  ldst_mmio_bridge_if bus ();

  ldst_mmio_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .ldst          (bus.slave),
    .o_ram_addr    (o_ram_addr),
    .o_ram_rd      (o_ram_rd),
    .o_ram_wr      (o_ram_wr),
    .o_ram_wrdata  (o_ram_wrdata),
    .o_ram_byte_en (o_ram_byte_en),
    .i_ram_rddata  (i_ram_rddata),
    .o_led         (o_led),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with one-cycle read latency
  always @(posedge clk) begin
    if (o_ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (o_ram_byte_en[b]) ram_mem[o_ram_addr[9:2]][8*b +: 8] <= o_ram_wrdata[8*b +: 8];
      end
    end
    if (o_ram_rd) i_ram_rddata <= ram_mem[o_ram_addr[9:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input logic [31:0] addr, input logic r, input logic w,
                         input logic [31:0] data, input logic [3:0] be);
    bus.i_ldst_addr    = addr;
    bus.i_ldst_rd      = r;
    bus.i_ldst_wr      = w;
    bus.i_ldst_wrdata  = data;
    bus.i_ldst_byte_en = be;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    set_bus(addr, 1'b0, 1'b1, data, be);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    set_bus(addr, 1'b1, 1'b0, 32'd0, 4'd0);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    data = bus.o_ldst_rddata;
  endtask

  task automatic tx_handshake();
    @(negedge clk);
    i_tx_ready = 1'b1;
    @(posedge clk);
    #1 i_tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_tx_ready = 1'b0;
    set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    #1;
    check_eq("rst_led", o_led, 32'h0);
    check_eq("rst_txv", 32'(o_tx_valid), 32'h0);
    check_eq("rst_rddata", bus.o_ldst_rddata, 32'h0);
    repeat (2) @(posedge clk);

    // First access lands on the first edge after reset release
    @(negedge clk);
    reset = 1'b0;
    set_bus(32'h0000_A000, 1'b0, 1'b1, 32'h1234_5678, 4'hF);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    check_eq("led_first", o_led, 32'h1234_5678);
    do_write(32'h0000_A000, 32'h0000_00AA, 4'b0001);
    check_eq("led_be", o_led, 32'h1234_56AA);
    do_read(32'h0000_A000, rd);
    check_eq("led_rd", rd, 32'h1234_56AA);

    // RAM passthrough
    @(negedge clk);
    set_bus(32'h0000_0100, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF);
    #1;
    check_eq("ram_wr", 32'(o_ram_wr), 32'h1);
    check_eq("ram_addr", o_ram_addr, 32'h0000_0100);
    check_eq("ram_wdata", o_ram_wrdata, 32'hDEAD_BEEF);
    check_eq("ram_be", 32'(o_ram_byte_en), 32'hF);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    do_read(32'h0000_0100, rd);
    check_eq("ram_rd", rd, 32'hDEAD_BEEF);

    // Read and write together: write wins, read returns 0
    @(negedge clk);
    set_bus(32'h0000_0104, 1'b1, 1'b1, 32'h1111_2222, 4'hF);
    #1 check_eq("rdwr_ram_rd", 32'(o_ram_rd), 32'h0);
    @(negedge clk);
    set_bus(32'h0000_A000, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hF);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    check_eq("rdwr_rddata", bus.o_ldst_rddata, 32'h0);
    check_eq("rdwr_led", o_led, 32'hCAFE_F00D);

    // Unmapped accesses
    @(negedge clk);
    set_bus(32'h0000_B000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    #1 check_eq("unmap_ramwr", 32'(o_ram_wr), 32'h0);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    check_eq("unmap_led", o_led, 32'hCAFE_F00D);
    do_read(32'h0000_B000, rd);
    check_eq("unmap_rd", rd, 32'h0);

    // TX overrun and W1C
    do_write(32'h0000_A004, 32'h41, 4'h1);
    do_write(32'h0000_A004, 32'h42, 4'h1);
    check_eq("tx_hold", 32'(o_tx_data), 32'h41);
    check_eq("tx_valid", 32'(o_tx_valid), 32'h1);
    do_read(32'h0000_A008, rd);
    check_eq("txstat_ovr", rd, 32'h3);
    tx_handshake();
    check_eq("tx_drain", 32'(o_tx_valid), 32'h0);
    do_write(32'h0000_A008, 32'h2, 4'h1);
    do_read(32'h0000_A008, rd);
    check_eq("txstat_clr", rd, 32'h0);

    // Write during handshake reloads without overrun
    do_write(32'h0000_A004, 32'h50, 4'h1);
    @(negedge clk);
    i_tx_ready = 1'b1;
    set_bus(32'h0000_A004, 1'b0, 1'b1, 32'h43, 4'h1);
    @(posedge clk);
    #1 set_bus(32'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    i_tx_ready = 1'b0;
    check_eq("hs_valid", 32'(o_tx_valid), 32'h1);
    check_eq("hs_data", 32'(o_tx_data), 32'h43);
    do_read(32'h0000_A008, rd);
    check_eq("hs_stat", rd, 32'h1);

    // byte_en[0]=0 suppresses a TXDATA write
    tx_handshake();
    do_write(32'h0000_A004, 32'h44, 4'b1110);
    check_eq("tx_be0", 32'(o_tx_valid), 32'h0);

    // Timer
`ifdef LDST_MMIO_TIMER_EN
    do_write(32'h0000_A010, 32'hFFFF_FF00, 4'b1110);
    do_read(32'h0000_A010, rd);
    check_eq("tcmp_be", rd, 32'hFFFF_FF00);
    do_write(32'h0000_A010, 32'h5, 4'hF);
    repeat (10) @(posedge clk);
    do_write(32'h0000_A014, 32'h1, 4'h1);
    do_write(32'h0000_A00C, 32'h0, 4'hF);
    do_read(32'h0000_A014, rd);
    check_eq("tstat_early", rd, 32'h0);
    repeat (3) @(posedge clk);
    do_read(32'h0000_A014, rd);
    check_eq("tstat_pre", rd, 32'h0);
    do_read(32'h0000_A014, rd);
    check_eq("tstat_set", rd, 32'h1);
    do_write(32'h0000_A014, 32'h1, 4'h1);
    do_read(32'h0000_A014, rd);
    check_eq("tstat_w1c", rd, 32'h0);
`else
    do_write(32'h0000_A010, 32'h5, 4'hF);
    do_write(32'h0000_A00C, 32'h0, 4'hF);
    repeat (8) @(posedge clk);
    do_read(32'h0000_A014, rd);
    check_eq("tstat_off", rd, 32'h0);
    do_read(32'h0000_A010, rd);
    check_eq("tcmp_off", rd, 32'h0);
`endif

    // Asynchronous reset mid-transmit
    do_write(32'h0000_A000, 32'h0000_00FF, 4'hF);
    do_write(32'h0000_A004, 32'h55, 4'h1);
    check_eq("pre_rst_txv", 32'(o_tx_valid), 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async_led", o_led, 32'h0);
    check_eq("async_txv", 32'(o_tx_valid), 32'h0);
    check_eq("async_txd", 32'(o_tx_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    i_tx_ready = 1'b1;
    @(posedge clk);
    #1 i_tx_ready = 1'b0;
    check_eq("post_rst_txv", 32'(o_tx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
